yonga_lz4_seq_decoder: RTL and testbench

Parametrised LZ4 block-sequence decoder core, the next-generation replacement for the fixed 128-byte-window decoder controller. It parses LZ4 tokens, literal/match length extensions and 16-bit offsets from a byte stream, emits decompressed bytes and keeps a circular history window of configurable depth for match copies. It sits between the compressed-input FIFO and the decompressed-output FIFO, both attached through valid/ready byte streams.

---
 rtl/yonga_lz4_seq_decoder_if.sv | 30 +++
 rtl/yonga_lz4_seq_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_yonga_lz4_seq_decoder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yonga_lz4_seq_decoder_if.sv
// Purpose: handshake/control bundle between the LZ4 sequence decoder and its neighbours.
// Latency: none (signal bundle only).
// Backpressure: carries both valid/ready byte streams; no logic here.
// Ports: i_enable/i_start control; compressed stream i_in_valid/o_in_ready/i_in_data/i_in_last;
//        decompressed stream o_out_valid/i_out_ready/o_out_data; status o_idle/o_done/o_err.
//        master = the side driving the decoder, slave = the decoder itself.
interface yonga_lz4_seq_decoder_if;
   logic       i_enable;
   logic       i_start;
   logic       i_in_valid;
   logic       o_in_ready;
   logic [7:0] i_in_data;
   logic       i_in_last;
   logic       o_out_valid;
   logic       i_out_ready;
   logic [7:0] o_out_data;
   logic       o_idle;
   logic       o_done;
   logic       o_err;

   modport master (
      output i_enable, i_start, i_in_valid, i_in_data, i_in_last, i_out_ready,
      input  o_in_ready, o_out_valid, o_out_data, o_idle, o_done, o_err
   );

   modport slave (
      input  i_enable, i_start, i_in_valid, i_in_data, i_in_last, i_out_ready,
      output o_in_ready, o_out_valid, o_out_data, o_idle, o_done, o_err
   );
endinterface

// File: rtl/yonga_lz4_seq_decoder.sv
// Purpose: LZ4 block-sequence decoder with a 2^HIST_AW-byte circular history window.
// Latency: literals pass through combinationally; match bytes 1/cycle; header bytes 1 cycle each.
// Backpressure: literals stall input on i_out_ready; matches hold o_out_valid/data until taken.
// Ports: clk, rst (async active-high); io_bus (slave modport) carries enable/start,
//        compressed byte stream in, decompressed byte stream out, idle/done/err status.
// Optional: define YONGA_LZ4_OFFSET_CHECK_EN to reject offsets of 0 or beyond the bytes
//           produced so far (capped at window depth); otherwise offsets wrap modulo the window.
module yonga_lz4_seq_decoder #(
   parameter int HIST_AW = 7,
   parameter int LEN_W   = 16
) (
   input logic                   clk,
   input logic                   rst,
   yonga_lz4_seq_decoder_if.slave io_bus
);
   localparam int DEPTH = 1 << HIST_AW;
   localparam int SUM_W = LEN_W + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_TOKEN, S_LIT_EXT, S_LIT_COPY, S_OFF_LO,
      S_OFF_HI, S_MAT_EXT, S_MAT_COPY, S_DONE, S_ERROR
   } state_t;

   state_t             r_state;
   state_t             w_nxt;

   logic [LEN_W-1:0]   r_lit_len;
   logic [LEN_W-1:0]   r_mat_len;
   logic               r_mat_ext;     // token low nibble was 15: match length extends
   logic [7:0]         r_off_lo;
   logic [15:0]        r_off;
   logic [HIST_AW-1:0] r_wr_ptr;
   logic               r_err;
   logic [7:0]         r_hist [DEPTH];

   logic               w_in_ready;
   logic               w_out_valid;
   logic [7:0]         w_out_data;
   logic               w_idle;
   logic               w_done;
   logic               w_in_xfer;
   logic               w_out_xfer;
   logic               w_start_acc;
   logic               w_last;
   logic [3:0]         w_tok_hi;
   logic [3:0]         w_tok_lo;
   logic [15:0]        w_offset;
   logic [SUM_W-1:0]   w_lit_sum;
   logic [SUM_W-1:0]   w_mat_sum;
   logic [HIST_AW-1:0] w_rd_addr;
   logic [7:0]         w_rd_data;
   logic               w_off_bad;

   assign w_tok_hi    = io_bus.i_in_data[7:4];
   assign w_tok_lo    = io_bus.i_in_data[3:0];
   assign w_last      = io_bus.i_in_last;
   assign w_offset    = {io_bus.i_in_data, r_off_lo};
   assign w_lit_sum   = {1'b0, r_lit_len} + SUM_W'(io_bus.i_in_data);
   assign w_mat_sum   = {1'b0, r_mat_len} + SUM_W'(io_bus.i_in_data);
   assign w_in_xfer   = io_bus.i_in_valid & w_in_ready;
   assign w_out_xfer  = w_out_valid & io_bus.i_out_ready;
   assign w_start_acc = (r_state == S_IDLE) & io_bus.i_start & io_bus.i_enable;

   // Match source is a fixed distance behind the write pointer; because every copied
   // byte is written back immediately, overlapping copies replicate the pattern.
   assign w_rd_addr   = r_wr_ptr - r_off[HIST_AW-1:0];
   assign w_rd_data   = r_hist[w_rd_addr];

`ifdef YONGA_LZ4_OFFSET_CHECK_EN
   localparam int PW = HIST_AW + 1;
   logic [PW-1:0] r_prod;   // bytes produced this block, saturating at the window depth

   assign w_off_bad = (w_offset == 16'd0) || (17'(w_offset) > 17'(r_prod));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_prod <= '0;
      else if (w_start_acc)
         r_prod <= '0;
      else if (w_out_xfer && !r_prod[HIST_AW])
         r_prod <= r_prod + PW'(1);
   end
`else
   assign w_off_bad = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_nxt;
   end

   // Next-state logic
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:
            if (w_start_acc) w_nxt = S_TOKEN;
         S_TOKEN:
            if (w_in_xfer) begin
               if (w_tok_hi == 4'hF)      w_nxt = w_last ? S_ERROR : S_LIT_EXT;
               else if (w_tok_hi != 4'h0) w_nxt = w_last ? S_ERROR : S_LIT_COPY;
               else                       w_nxt = w_last ? S_DONE  : S_OFF_LO;
            end
         S_LIT_EXT:
            if (w_in_xfer) begin
               if (w_last || w_lit_sum[LEN_W])   w_nxt = S_ERROR;
               else if (io_bus.i_in_data != 8'hFF) w_nxt = S_LIT_COPY;
            end
         S_LIT_COPY:
            if (w_out_xfer) begin
               if (r_lit_len == LEN_W'(1)) w_nxt = w_last ? S_DONE : S_OFF_LO;
               else if (w_last)            w_nxt = S_ERROR;
            end
         S_OFF_LO:
            if (w_in_xfer) w_nxt = w_last ? S_ERROR : S_OFF_HI;
         S_OFF_HI:
            if (w_in_xfer) begin
               if (w_last || w_off_bad) w_nxt = S_ERROR;
               else if (r_mat_ext)      w_nxt = S_MAT_EXT;
               else                     w_nxt = S_MAT_COPY;
            end
         S_MAT_EXT:
            if (w_in_xfer) begin
               if (w_last || w_mat_sum[LEN_W])   w_nxt = S_ERROR;
               else if (io_bus.i_in_data != 8'hFF) w_nxt = S_MAT_COPY;
            end
         S_MAT_COPY:
            if (w_out_xfer && (r_mat_len == LEN_W'(1))) w_nxt = S_TOKEN;
         S_DONE:
            w_nxt = S_IDLE;
         S_ERROR:
            if (io_bus.i_start) w_nxt = S_IDLE;
         default:
            w_nxt = S_IDLE;
      endcase
      // Disable overrides everything, including a pending error.
      if (!io_bus.i_enable) w_nxt = S_IDLE;
   end

   // Output logic
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_out_data  = 8'h00;
      w_idle      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE:
            w_idle = 1'b1;
         S_TOKEN, S_LIT_EXT, S_OFF_LO, S_OFF_HI, S_MAT_EXT:
            w_in_ready = 1'b1;
         S_LIT_COPY: begin
            // Pass-through: the only combinational ready path in the design.
            w_in_ready  = io_bus.i_out_ready;
            w_out_valid = io_bus.i_in_valid;
            w_out_data  = io_bus.i_in_data;
         end
         S_MAT_COPY: begin
            w_out_valid = 1'b1;
            w_out_data  = w_rd_data;
         end
         S_DONE:
            w_done = 1'b1;
         default: ;
      endcase
   end

   assign io_bus.o_in_ready  = w_in_ready;
   assign io_bus.o_out_valid = w_out_valid;
   assign io_bus.o_out_data  = w_out_data;
   assign io_bus.o_idle      = w_idle;
   assign io_bus.o_done      = w_done;
   assign io_bus.o_err       = r_err;

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lit_len <= '0;
         r_mat_len <= '0;
         r_mat_ext <= 1'b0;
         r_off_lo  <= 8'h00;
         r_off     <= 16'h0000;
         r_wr_ptr  <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_wr_ptr <= '0;
            r_err    <= 1'b0;
         end else if (w_out_xfer) begin
            r_wr_ptr <= r_wr_ptr + HIST_AW'(1);
         end

         if (w_nxt == S_ERROR) r_err <= 1'b1;

         if (w_in_xfer) begin
            case (r_state)
               S_TOKEN: begin
                  r_lit_len <= LEN_W'(w_tok_hi);
                  r_mat_len <= LEN_W'(w_tok_lo) + LEN_W'(4);
                  r_mat_ext <= (w_tok_lo == 4'hF);
               end
               S_LIT_EXT:  r_lit_len <= w_lit_sum[LEN_W-1:0];
               S_LIT_COPY: r_lit_len <= r_lit_len - LEN_W'(1);
               S_OFF_LO:   r_off_lo  <= io_bus.i_in_data;
               S_OFF_HI:   r_off     <= w_offset;
               S_MAT_EXT:  r_mat_len <= w_mat_sum[LEN_W-1:0];
               default: ;
            endcase
         end

         if ((r_state == S_MAT_COPY) && w_out_xfer)
            r_mat_len <= r_mat_len - LEN_W'(1);
      end
   end

   // History window: every emitted byte (literal or copy) is recorded; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_out_xfer) r_hist[r_wr_ptr] <= w_out_data;
   end
endmodule

// File: tb/tb_yonga_lz4_seq_decoder.sv
// Purpose: self-checking bench for yonga_lz4_seq_decoder (table vectors + corner sequences).
// Latency: n/a.
// Backpressure: exercises a 1-0-0-1 i_out_ready pattern with stall-stability checks.
module tb_yonga_lz4_seq_decoder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   yonga_lz4_seq_decoder_if bus();

   yonga_lz4_seq_decoder #(.HIST_AW(7), .LEN_W(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   typedef struct {
      byte unsigned din[280];
      int           n_in;
      byte unsigned dout[280];
      int           n_out;
      bit           exp_done;
      bit           exp_err;
   } vec_t;

   localparam int NV = 7;
   localparam logic [3:0] BP = 4'b1001;

   vec_t         vt[NV];
   vec_t         vx;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           done_cnt = 0;
   byte unsigned exp_q[$];
   bit           chk_stable = 1'b0;
   bit           prev_stall = 1'b0;
   logic [7:0]   prev_data = 8'h00;
   bit           bp_en = 1'b0;
   bit           rdy_force = 1'b1;
   logic [1:0]   bp_idx = 2'd0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk_vec(input int ni, input logic [191:0] bi,
                                   input int no, input logic [191:0] bo,
                                   input bit d, input bit e);
      vec_t v;
      v.n_in = ni;
      v.n_out = no;
      v.exp_done = d;
      v.exp_err = e;
      for (int i = 0; i < ni; i++) v.din[i] = bi[8*(ni-1-i) +: 8];
      for (int i = 0; i < no; i++) v.dout[i] = bo[8*(no-1-i) +: 8];
      return v;
   endfunction

   function automatic byte unsigned pat(input int i);
      return byte'(i * 7 + 3);
   endfunction

   // Output ready driver
   initial begin
      bus.i_out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.i_out_ready = bp_en ? BP[bp_idx] : rdy_force;
         bp_idx = bp_idx + 2'd1;
      end
   end

   // Output monitor / scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_done) done_cnt++;
         if (chk_stable && prev_stall) begin
            chk("stall_valid", int'(bus.o_out_valid), 1);
            chk("stall_data", int'(bus.o_out_data), int'(prev_data));
         end
         prev_stall = bus.o_out_valid && !bus.i_out_ready;
         prev_data  = bus.o_out_data;
         if (bus.o_out_valid && bus.i_out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL out_unexpected: got %02h, expected no output", bus.o_out_data);
            end else begin
               chk("out_byte", int'(bus.o_out_data), int'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic drive_byte(input logic [7:0] d, input logic last, output bit ok);
      bit acc;
      bit stop;
      ok = 1'b0;
      bus.i_in_valid = 1'b1;
      bus.i_in_data  = d;
      bus.i_in_last  = last;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         acc  = bus.o_in_ready;
         stop = bus.o_err && !acc;
         @(posedge clk);
         #1;
         if (acc || stop) begin
            ok = acc;
            break;
         end
      end
      bus.i_in_valid = 1'b0;
      bus.i_in_last  = 1'b0;
   endtask

   task automatic run_block(input vec_t v, input int id);
      bit ok;
      bit settled;
      settled = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (bus.o_idle) begin
            settled = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_idle_before", id), int'(settled), 1);
      for (int i = 0; i < v.n_out; i++) exp_q.push_back(v.dout[i]);
      done_cnt = 0;
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      chk($sformatf("vec%0d_err_clear", id), int'(bus.o_err), 0);
      ok = 1'b1;
      for (int i = 0; i < v.n_in; i++) begin
         drive_byte(8'(v.din[i]), (i == v.n_in - 1), ok);
         if (!ok) break;
      end
      if (!ok && !bus.o_err) begin
         n_cmp++;
         n_bad++;
         $display("FAIL vec%0d_drive_timeout: byte not accepted, expected acceptance", id);
      end
      settled = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ((bus.o_idle || bus.o_err) && exp_q.size() == 0) begin
            settled = 1'b1;
            break;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_settled", id), int'(settled), 1);
      chk($sformatf("vec%0d_done_cnt", id), done_cnt, int'(v.exp_done));
      chk($sformatf("vec%0d_err", id), int'(bus.o_err), int'(v.exp_err));
      chk($sformatf("vec%0d_missing_out", id), exp_q.size(), 0);
      exp_q.delete();
      if (v.exp_err) begin
         bus.i_start = 1'b1;
         @(posedge clk);
         #1;
         bus.i_start = 1'b0;
         chk($sformatf("vec%0d_err_sticky", id), int'(bus.o_err), 1);
         chk($sformatf("vec%0d_err_exit_idle", id), int'(bus.o_idle), 1);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      vt[0] = mk_vec(4, {8'h30, 8'h61, 8'h62, 8'h63}, 3, {8'h61, 8'h62, 8'h63}, 1'b1, 1'b0);
      vt[1] = mk_vec(6, {8'h11, 8'h61, 8'h01, 8'h00, 8'h10, 8'h62},
                     7, {{6{8'h61}}, 8'h62}, 1'b1, 1'b0);
      vt[2] = mk_vec(2, {8'h20, 8'h78}, 1, {8'h78}, 1'b0, 1'b1);
      vt[3] = mk_vec(1, {8'h00}, 0, 192'd0, 1'b1, 1'b0);
      vt[4] = mk_vec(6, {8'h1F, 8'h7A, 8'h01, 8'h00, 8'h02, 8'h00},
                     22, {22{8'h7A}}, 1'b1, 1'b0);
      vt[5] = mk_vec(3, {8'h10, 8'h61, 8'h01}, 1, {8'h61}, 1'b0, 1'b1);
      vt[6] = mk_vec(7, {8'h20, 8'h41, 8'h42, 8'h02, 8'h00, 8'h10, 8'h43},
                     7, {8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42, 8'h43}, 1'b1, 1'b0);

      rst = 1'b1;
      bus.i_enable   = 1'b0;
      bus.i_start    = 1'b0;
      bus.i_in_valid = 1'b0;
      bus.i_in_data  = 8'h00;
      bus.i_in_last  = 1'b0;

      @(negedge clk);
      chk("rst_in_ready", int'(bus.o_in_ready), 0);
      chk("rst_out_valid", int'(bus.o_out_valid), 0);
      chk("rst_out_data", int'(bus.o_out_data), 0);
      chk("rst_idle", int'(bus.o_idle), 1);
      chk("rst_done", int'(bus.o_done), 0);
      chk("rst_err", int'(bus.o_err), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_enable = 1'b1;

      for (int k = 0; k < NV; k++) run_block(vt[k], k);

      // 272 literals through two length-extension bytes
      vx.n_in = 275;
      vx.n_out = 272;
      vx.exp_done = 1'b1;
      vx.exp_err = 1'b0;
      vx.din[0] = 8'hF0;
      vx.din[1] = 8'hFF;
      vx.din[2] = 8'h02;
      for (int i = 0; i < 272; i++) begin
         vx.din[3 + i] = pat(i);
         vx.dout[i] = pat(i);
      end
      run_block(vx, 10);

      // Overlap match under output backpressure
      bp_en = 1'b1;
      chk_stable = 1'b1;
      run_block(vt[1], 11);
      bp_en = 1'b0;
      chk_stable = 1'b0;

      // Offset 0x0500: window-aligned, so without the check it re-reads history from wr_ptr 0
`ifdef YONGA_LZ4_OFFSET_CHECK_EN
      vx = mk_vec(4, {8'h01, 8'h00, 8'h05, 8'h00}, 0, 192'd0, 1'b0, 1'b1);
`else
      vx = mk_vec(4, {8'h01, 8'h00, 8'h05, 8'h00}, 5, {5{8'h61}}, 1'b1, 1'b0);
`endif
      run_block(vx, 12);

      // Enable dropped mid-block
      done_cnt = 0;
      exp_q.push_back(8'h61);
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      drive_byte(8'h30, 1'b0, ok);
      drive_byte(8'h61, 1'b0, ok);
      bus.i_enable = 1'b0;
      @(posedge clk);
      #1;
      chk("en_drop_idle", int'(bus.o_idle), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("en_drop_no_done", done_cnt, 0);
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      chk("start_blocked", int'(bus.o_idle), 1);
      bus.i_enable = 1'b1;
      chk("en_drop_out_count", exp_q.size(), 0);

      // Reset asserted while a match copy is stalled
      exp_q.push_back(8'h71);
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      drive_byte(8'h11, 1'b0, ok);
      drive_byte(8'h71, 1'b0, ok);
      rdy_force = 1'b0;
      drive_byte(8'h01, 1'b0, ok);
      drive_byte(8'h00, 1'b0, ok);
      @(negedge clk);
      chk("stall_copy_valid", int'(bus.o_out_valid), 1);
      chk("stall_copy_data", int'(bus.o_out_data), 8'h71);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", int'(bus.o_out_valid), 0);
      chk("rst_mid_out_data", int'(bus.o_out_data), 0);
      chk("rst_mid_in_ready", int'(bus.o_in_ready), 0);
      chk("rst_mid_idle", int'(bus.o_idle), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_force = 1'b1;
      chk("rst_mid_out_count", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
